// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier and its downstream collectors.
package mul_pkg;

    localparam int unsigned PRODUCT_W     = 64;
    localparam int unsigned ACC_W_DEFAULT = 72;

    typedef enum logic {
        IDLE,
        ACCUM
    } collector_state_t;

    typedef logic [PRODUCT_W-1:0] product_t;

endpackage

// File: rtl/mul_accumulate_collector_if.sv
// Product beat input and completed-sum output handshake of the collector.
interface mul_accumulate_collector_if
    import mul_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT
);
    logic             valid_in;
    product_t         product;
    logic             sum_valid;
    logic             sum_ready;
    logic [ACC_W-1:0] sum;

    // Producer/consumer side: feeds products, drains sums.
    modport master (
        output valid_in,
        output product,
        output sum_ready,
        input  sum_valid,
        input  sum
    );

    // Collector side.
    modport slave (
        input  valid_in,
        input  product,
        input  sum_ready,
        output sum_valid,
        output sum
    );
endinterface

// File: rtl/sum_queue.sv
// Small FIFO of completed results; push while full is refused unless a pop frees a slot on the same edge.
module sum_queue #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Masked so the head reads zero whenever nothing is queued.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage write; entries need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mul_accumulate_collector.sv
// Sums GROUP_LEN consecutive multiplier products and queues each completed sum for a downstream consumer.
module mul_accumulate_collector
    import mul_pkg::*;
#(
    parameter int unsigned GROUP_LEN = 4,
    parameter int unsigned ACC_W     = ACC_W_DEFAULT,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    mul_accumulate_collector_if.slave   bus,
    output logic                        busy,
    output logic                        drop_err
);
    collector_state_t state;
    logic [7:0]       beat_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             beat_fire;
    logic             last_beat;
    logic             push;
    logic             pop;
    logic             q_full;
    logic             q_empty;
    logic [ACC_W-1:0] q_head;

    // The multiplier launches on negedge, so product is stable at posedge without a synchroniser.
    assign beat_fire     = bus.valid_in && !clear;
    assign last_beat     = (beat_cnt == 8'(GROUP_LEN - 1));
    assign acc_next      = acc + ACC_W'(bus.product);
    assign push          = beat_fire && last_beat;
    assign pop           = bus.sum_valid && bus.sum_ready;
    assign bus.sum_valid = !q_empty;
    assign bus.sum       = q_head;

    sum_queue #(
        .WIDTH (ACC_W),
        .DEPTH (QDEPTH)
    ) u_sum_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (acc_next),
        .full  (q_full),
        .empty (q_empty),
        .head  (q_head)
    );

    // Group FSM: accumulates beats, restarts on the final beat with no bubble, flags refused pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
            drop_err <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            acc      <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            if (push && q_full && !pop) drop_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (beat_fire && !last_beat) begin
                        state    <= ACCUM;
                        acc      <= acc_next;
                        beat_cnt <= 8'd1;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat_fire) begin
                        if (last_beat) begin
                            state    <= IDLE;
                            acc      <= '0;
                            beat_cnt <= '0;
                            busy     <= 1'b0;
                        end else begin
                            acc      <= acc_next;
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    acc      <= '0;
                    beat_cnt <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_accumulate_collector.sv
// Bench for mul_accumulate_collector: table-driven groups, scoreboard on the sum handshake, corner-case sequences.
module tb_mul_accumulate_collector;
    import mul_pkg::*;

    localparam int unsigned GL = 4;
    localparam int unsigned AW = 72;
    localparam int unsigned QD = 2;

    typedef struct packed {
        logic [3:0][63:0] p;
        logic [AW-1:0]    exp;
    } grp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic busy;
    logic drop_err;

    int total = 0;
    int bad   = 0;
    logic [AW-1:0] exp_q[$];
    grp_t tbl[6];

    mul_accumulate_collector_if #(.ACC_W(AW)) bus ();

    mul_accumulate_collector #(
        .GROUP_LEN (GL),
        .ACC_W     (AW),
        .QDEPTH    (QD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .bus      (bus),
        .busy     (busy),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Inputs change on negedge, like the multiplier's registered outputs.
    task automatic drive(input logic v, input product_t p, input logic rdy);
        @(negedge clk);
        bus.valid_in  = v;
        bus.product   = p;
        bus.sum_ready = rdy;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) drive(1'b0, '0, 1'b1);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d sums still pending, expected 0", name, exp_q.size());
        end
    endtask

    function automatic grp_t mk(input product_t a, input product_t b, input product_t c,
                                input product_t d, input logic [AW-1:0] e);
        grp_t g;
        g.p[0] = a;
        g.p[1] = b;
        g.p[2] = c;
        g.p[3] = d;
        g.exp  = e;
        return g;
    endfunction

    // Scoreboard: every accepted sum must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.sum_valid && bus.sum_ready) begin
                if (exp_q.size() == 0) chk1("sb_spurious_valid", bus.sum_valid, 1'b0);
                else                   chk("sb_sum", bus.sum, exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] gap_v;

        tbl[0] = mk(64'd1, 64'd2, 64'd3, 64'd4, 72'd10);
        tbl[1] = mk('1, '1, '1, '1, 72'h3_FFFF_FFFF_FFFF_FFFC);
        tbl[2] = mk(64'd0, 64'd0, 64'd0, 64'd0, 72'd0);
        tbl[3] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 72'h2_0000_0000_0000_0000);
        tbl[4] = mk(64'd5, 64'd6, 64'd7, 64'd8, 72'd26);
        tbl[5] = mk(64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0,
                    72'h1_0000_0000_0000_0000);

        bus.valid_in  = 1'b0;
        bus.product   = '0;
        bus.sum_ready = 1'b0;

        // Reset state.
        #12;
        chk1("rst_sum_valid", bus.sum_valid, 1'b0);
        chk("rst_sum", bus.sum, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_drop_err", drop_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1,2,3,4 -> 10, valid for exactly one cycle.
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, product_t'(b + 1), 1'b1);
            if (b == 3) exp_q.push_back(72'd10);
            after_edge();
            chk1("t1_busy", busy, (b < 3));
        end
        chk1("t1_valid_rise", bus.sum_valid, 1'b1);
        chk("t1_sum", bus.sum, 72'd10);
        drive(1'b0, '0, 1'b1);
        after_edge();
        chk1("t1_valid_one_cycle", bus.sum_valid, 1'b0);
        chk1("t1_busy_after", busy, 1'b0);

        // Table of groups, back to back.
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < 4; b++) begin
                drive(1'b1, tbl[i].p[b], 1'b1);
                if (b == 3) exp_q.push_back(tbl[i].exp);
            end
        end
        wait_drain("tbl_drain");

        // Backpressure: three groups of 1s, third dropped.
        for (int b = 0; b < 12; b++) begin
            drive(1'b1, 64'd1, 1'b0);
            if (b == 3 || b == 7) exp_q.push_back(72'd4);
            if (b == 7) begin
                after_edge();
                chk1("bp_no_drop_yet", drop_err, 1'b0);
            end
        end
        after_edge();
        chk1("bp_drop_err", drop_err, 1'b1);
        chk1("bp_valid", bus.sum_valid, 1'b1);
        chk("bp_head", bus.sum, 72'd4);
        wait_drain("bp_drain");
        after_edge();
        chk1("bp_empty", bus.sum_valid, 1'b0);
        chk1("bp_sticky", drop_err, 1'b1);

        // clear resets drop_err.
        @(negedge clk);
        bus.valid_in = 1'b0;
        clear = 1'b1;
        after_edge();
        chk1("clr_drop_err", drop_err, 1'b0);
        @(negedge clk);
        clear = 1'b0;

        // Asynchronous reset mid-group with a queued sum.
        for (int b = 0; b < 4; b++) drive(1'b1, 64'd1, 1'b0);
        drive(1'b1, 64'd5, 1'b0);
        drive(1'b1, 64'd5, 1'b0);
        after_edge();
        chk1("pre_rst_busy", busy, 1'b1);
        chk1("pre_rst_valid", bus.sum_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("arst_valid", bus.sum_valid, 1'b0);
        chk("arst_sum", bus.sum, '0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_drop_err", drop_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.valid_in = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 64'd1, 1'b1);
            if (b == 3) exp_q.push_back(72'd4);
        end
        wait_drain("arst_drain");

        // Gapped beats: 1,0,0,1,1,0,1 of 7 -> 28.
        gap_v = 7'b1011001;
        for (int k = 0; k < 7; k++) begin
            drive(gap_v[k], gap_v[k] ? 64'd7 : 64'd0, 1'b1);
            if (k == 6) exp_q.push_back(72'd28);
            after_edge();
            chk1("gap_busy", busy, (k < 6));
        end
        wait_drain("gap_drain");

        // Full queue with push and pop on the same edge.
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, product_t'(b + 1), 1'b0);
            if (b == 3) exp_q.push_back(72'd10);
        end
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 64'd5, 1'b0);
            if (b == 3) exp_q.push_back(72'd20);
        end
        for (int b = 0; b < 3; b++) drive(1'b1, 64'd3, 1'b0);
        drive(1'b1, 64'd3, 1'b1);
        exp_q.push_back(72'd12);
        after_edge();
        chk1("pp_no_drop", drop_err, 1'b0);
        chk1("pp_valid", bus.sum_valid, 1'b1);
        wait_drain("pp_drain");
        chk1("pp_no_drop_end", drop_err, 1'b0);

        // clear together with valid_in, with a queued sum and a partial group.
        for (int b = 0; b < 4; b++) drive(1'b1, 64'd1, 1'b0);
        drive(1'b1, 64'd1, 1'b0);
        drive(1'b1, 64'd1, 1'b0);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.product  = 64'd9;
        clear        = 1'b1;
        after_edge();
        chk1("cv_busy", busy, 1'b0);
        chk1("cv_valid", bus.sum_valid, 1'b0);
        @(negedge clk);
        clear        = 1'b0;
        bus.valid_in = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 64'd2, 1'b1);
            if (b == 3) exp_q.push_back(72'd8);
        end
        wait_drain("cv_drain");
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
        chk1("end_idle_valid", bus.sum_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_accumulate_collector.md
Name: mul_accumulate_collector

Overview:
- Downstream consumer of the 32x32 parallel multiplier.
- Takes one unsigned 64-bit product per valid beat and sums GROUP_LEN consecutive products into a wide accumulator.
- Pushes each completed sum into a small output queue that a downstream block drains with a valid/ready handshake.
- The multiplier cannot be stalled, so this block absorbs all backpressure and flags loss. It never stalls upstream.

Parameters:
- GROUP_LEN, 4, products per accumulated sum (1..255).
- ACC_W, 72, accumulator and sum width (≥ 64 + clog2(GROUP_LEN)).
- QDEPTH, 2, output queue depth in completed sums (power of 2, ≥ 2).

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: discards the partial sum and empties the queue.
- valid_in  input  1  product beat present; driven from the multiplier's valid_out.
- product  input  64  unsigned product; driven from the multiplier's r.
- sum_valid  output  1  queue head holds a completed sum.
- sum_ready  input  1  consumer accepts the head this cycle.
- sum  output  ACC_W  queue head value.
- busy  output  1  partial group in progress (beat_cnt != 0).
- drop_err  output  1  sticky: a completed sum was discarded because the queue was full.

Behaviour:
- Reset (rst_n low, asynchronous): accumulator = 0, beat_cnt = 0, queue empty, sum_valid = 0, sum = 0, busy = 0, drop_err = 0. Reset mid-group discards the partial sum.
- Sampling:
  - The multiplier registers its outputs on negedge clk. This block samples valid_in and product on posedge clk, half a cycle later, with no extra synchroniser.
- Accumulation:
  - On each posedge with valid_in = 1, acc_next = acc + zero-extended product (ACC_W bits, unsigned, no saturation), and beat_cnt increments.
  - When the beat makes beat_cnt reach GROUP_LEN, acc_next is pushed into the queue.
  - On that same edge, acc and beat_cnt return to 0, so the next beat starts a new group with no bubble.
- Latency: the completed sum appears at sum with sum_valid = 1 on the edge after the final product is sampled, if the queue was empty. Back-to-back groups are sustained at one beat per cycle.
- FSM (2 states):
  - IDLE: beat_cnt = 0. valid_in → ACCUM; if GROUP_LEN = 1, push and stay in IDLE.
  - ACCUM: count beats. The final beat → IDLE with push.
  - clear → IDLE from either state.
- Queue:
  - FIFO of QDEPTH entries, with wrap-around read/write pointers plus a count.
  - Pop occurs on sum_valid && sum_ready.
  - sum is the head entry; it holds its value while sum_valid && !sum_ready.
- Boundaries:
  - Push and pop on the same edge with the queue full: legal, both occur, and no drop.
  - Push with the queue full and no pop: the new sum is discarded, drop_err is set to 1, and the queue contents are unchanged.
  - drop_err clears only on reset or clear.
  - Pop when empty: ignored.
  - clear together with valid_in: clear wins and the beat is discarded.
  - clear: queue empties, sum_valid = 0 on the next edge, drop_err = 0.
  - Accumulator overflow beyond ACC_W wraps modulo 2^ACC_W. This cannot occur when the ACC_W rule is met.
- busy = (beat_cnt != 0).

Decomposition:
- Shared package mul_pkg:
  - PRODUCT_W = 64.
  - Default ACC_W.
  - typedef for the collector state enum {IDLE, ACCUM}.
  - typedef logic[PRODUCT_W-1:0] product_t.
- Sub-module sum_queue: parameterised FIFO (WIDTH, DEPTH) with push, pop, full, empty, and head.
  - It is instantiated once and is reusable by other functional-unit collectors.

Test Plan:
- GROUP_LEN = 4. Four consecutive beats with products 1, 2, 3, 4 and sum_ready = 1 → sum = 10 with sum_valid high for exactly one cycle, on the edge after the 4th beat; busy = 0 afterwards.
- Four beats of 0xFFFF_FFFF_FFFF_FFFF → sum = 0x3_FFFF_FFFF_FFFF_FFFC (no truncation at 64 bits).
- sum_ready = 0 and three full groups (12 beats of value 1) → queue holds 4 and 4, the third sum is dropped, drop_err = 1. Then raise sum_ready → pops 4, 4, then sum_valid = 0.
- Two beats of value 5, then rst_n pulsed low between clock edges → all outputs 0 immediately. The next four beats of 1 → sum = 4 (the partial group is lost).
- Beats with gaps (valid_in pattern 1,0,0,1,1,0,1, product 7 on each valid beat) → single sum = 28. busy is high from the first beat until the push.
- Queue full with a push and pop on the same edge → no drop and drop_err stays 0. clear asserted together with valid_in → beat ignored, queue empty, busy = 0.
